// File: rtl/lcd_pkg.sv
// Shared types and constants for the memory-mapped HD44780-style LCD controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } lcd_state_e;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CMD    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;

   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_FULL    = 1;
   localparam int unsigned STAT_EMPTY   = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_W   = 5;

   localparam logic [7:0] OP_CLEAR     = 8'h01;
   localparam logic [7:0] OP_HOME      = 8'h02;
   localparam logic [7:0] OP_HOME_ALT  = 8'h03;

   // Clear and return-home commands need the long post-command gap.
   function automatic logic is_slow_op(input logic rs, input logic [7:0] b);
      return !rs && (b == OP_CLEAR || b == OP_HOME || b == OP_HOME_ALT);
   endfunction

endpackage

// File: rtl/lcd_controller_if.sv
// CPU-side register bus of the LCD controller.
interface lcd_controller_if;
   logic        wr_en;
   logic [1:0]  addr;
   logic [7:0]  wdata;
   logic [31:0] rdata;

   modport master (output wr_en, output addr, output wdata, input rdata);
   modport slave  (input wr_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/lcd_controller_sync_fifo.sv
// Synchronous FIFO with flush; head is visible combinationally on dout.
module sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
         else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/lcd_controller.sv
// Memory-mapped LCD controller: queues data/command bytes and sequences the
// setup / enable pulse / hold / post-command wait timing on the LCD pins.
module lcd_controller
   import lcd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH       = 8,
   parameter int unsigned SETUP_CYCLES     = 2,
   parameter int unsigned PULSE_CYCLES     = 4,
   parameter int unsigned HOLD_CYCLES      = 2,
   parameter int unsigned CMD_WAIT_CYCLES  = 50,
   parameter int unsigned SLOW_WAIT_CYCLES = 2000
) (
   input  logic             clk,
   input  logic             rst,
   lcd_controller_if.slave  bus,
   output logic [7:0]       lcd_data,
   output logic [1:0]       lcd_ctrl,
   output logic             lcd_enable,
   output logic             busy
);
   localparam int unsigned CNT_W  = $clog2(SLOW_WAIT_CYCLES + 1);
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

   lcd_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        lcd_data_q, lcd_data_d;
   logic [1:0]        lcd_ctrl_q, lcd_ctrl_d;
   logic              lcd_enable_q, lcd_enable_d;
   logic              ovf_q, ovf_d;

   logic              push_req, status_wr, flush, ovf_clr, fifo_pop;
   logic [8:0]        fifo_din, fifo_dout;
   logic              fifo_full, fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic [31:0]       status;

   assign push_req  = bus.wr_en && (bus.addr == ADDR_DATA || bus.addr == ADDR_CMD);
   assign status_wr = bus.wr_en && (bus.addr == ADDR_STATUS);
   assign flush     = status_wr && bus.wdata[0];
   assign ovf_clr   = status_wr && bus.wdata[1];
   assign fifo_din  = {bus.addr == ADDR_DATA, bus.wdata};

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (fifo_pop),
      .flush (flush),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lcd_data_d = lcd_data_q;
      lcd_ctrl_d = lcd_ctrl_q;
      fifo_pop   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               lcd_ctrl_d = {fifo_dout[8], 1'b0};
               lcd_data_d = fifo_dout[7:0];
               cnt_d      = CNT_W'(SETUP_CYCLES - 1);
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(PULSE_CYCLES - 1);
               state_d = ST_PULSE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               cnt_d   = is_slow_op(lcd_ctrl_q[1], lcd_data_q) ? CNT_W'(SLOW_WAIT_CYCLES - 1)
                                                               : CNT_W'(CMD_WAIT_CYCLES - 1);
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      // Enable is registered off the next state so the pin changes cleanly at the edge.
      lcd_enable_d = (state_d == ST_PULSE);
   end

   always_comb begin
      ovf_d = ovf_q;
      if (push_req && fifo_full) ovf_d = 1'b1;
      else if (ovf_clr)          ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         lcd_data_q   <= '0;
         lcd_ctrl_q   <= '0;
         lcd_enable_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lcd_data_q   <= lcd_data_d;
         lcd_ctrl_q   <= lcd_ctrl_d;
         lcd_enable_q <= lcd_enable_d;
         ovf_q        <= ovf_d;
      end
   end

   assign lcd_data   = lcd_data_q;
   assign lcd_ctrl   = lcd_ctrl_q;
   assign lcd_enable = lcd_enable_q;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;

   always_comb begin
      status                                  = '0;
      status[STAT_BUSY]                       = busy;
      status[STAT_FULL]                       = fifo_full;
      status[STAT_EMPTY]                      = fifo_empty;
      status[STAT_OVF]                        = ovf_q;
      status[STAT_CNT_LSB +: STAT_CNT_W]      = STAT_CNT_W'(fifo_count);
      bus.rdata = (bus.addr == ADDR_STATUS) ? status : '0;
   end

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller: directed scenarios plus random traffic, every cycle
// compared against a transaction-timing model of the controller.
module tb_lcd_controller;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned S     = 2;
   localparam int unsigned PU    = 4;
   localparam int unsigned H     = 2;
   localparam int unsigned CW    = 50;
   localparam int unsigned SW    = 2000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lcd_controller_if bus();
   logic [7:0] lcd_data;
   logic [1:0] lcd_ctrl;
   logic       lcd_enable;
   logic       busy;

   lcd_controller #(
      .FIFO_DEPTH       (DEPTH),
      .SETUP_CYCLES     (S),
      .PULSE_CYCLES     (PU),
      .HOLD_CYCLES      (H),
      .CMD_WAIT_CYCLES  (CW),
      .SLOW_WAIT_CYCLES (SW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .lcd_data   (lcd_data),
      .lcd_ctrl   (lcd_ctrl),
      .lcd_enable (lcd_enable),
      .busy       (busy)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;

   // Model: queue of pending {rs,byte}, plus start/finish edges of the current transfer.
   logic [8:0]  mq[$];
   bit          m_ovf = 1'b0;
   bit          m_act = 1'b0;
   int unsigned m_pop = 0;
   int unsigned m_end = 0;
   logic [8:0]  m_cur = '0;

   bit          prev_en = 1'b0;
   int unsigned n_rise = 0;
   int unsigned last_rise = 0;
   int unsigned last_fall = 0;
   int unsigned last_busy = 0;
   logic [7:0]  rise_data[$];

   function automatic int unsigned wait_of(logic [8:0] e);
      if (!e[8] && (e[7:0] == 8'h01 || e[7:0] == 8'h02 || e[7:0] == 8'h03)) return SW;
      return CW;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
   endtask

   task automatic model_edge(bit r, bit w, logic [1:0] a, logic [7:0] d);
      int unsigned pre_size;
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_act = 1'b0;
         m_cur = '0;
         return;
      end
      pre_size = mq.size();
      if ((!m_act || cyc > m_end) && pre_size > 0) begin
         m_cur = mq.pop_front();
         m_act = 1'b1;
         m_pop = cyc;
         m_end = cyc + S + PU + H + wait_of(m_cur);
      end
      if (w) begin
         if (a == 2'd0 || a == 2'd1) begin
            if (pre_size == DEPTH) m_ovf = 1'b1;
            else                   mq.push_back({a == 2'd0, d});
         end else if (a == 2'd2) begin
            if (d[0]) mq.delete();
            if (d[1]) m_ovf = 1'b0;
         end
      end
   endtask

   task automatic check_outputs(logic [1:0] a);
      logic        exp_en, exp_busy;
      logic [31:0] st;
      int unsigned n;
      n        = mq.size();
      exp_en   = m_act && (cyc >= m_pop + S) && (cyc < m_pop + S + PU);
      exp_busy = (m_act && cyc < m_end) || (n != 0);
      st       = '0;
      st[0]    = exp_busy;
      st[1]    = (n == DEPTH);
      st[2]    = (n == 0);
      st[3]    = m_ovf;
      st[8:4]  = 5'(n);
      chk("lcd_enable", 32'(lcd_enable), 32'(exp_en));
      chk("lcd_data",   32'(lcd_data),   32'(m_cur[7:0]));
      chk("lcd_ctrl",   32'(lcd_ctrl),   32'({m_cur[8], 1'b0}));
      chk("busy",       32'(busy),       32'(exp_busy));
      chk("rdata",      bus.rdata,       (a == 2'd2) ? st : 32'h0);
   endtask

   task automatic tick(bit r, bit w, logic [1:0] a, logic [7:0] d);
      rst       = r;
      bus.wr_en = w;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      cyc++;
      model_edge(r, w, a, d);
      #1;
      check_outputs(a);
      if (lcd_enable && !prev_en) begin
         n_rise++;
         last_rise = cyc;
         rise_data.push_back(lcd_data);
      end
      if (!lcd_enable && prev_en) last_fall = cyc;
      if (busy) last_busy = cyc;
      prev_en = lcd_enable;
   endtask

   task automatic idle(int unsigned n);
      for (int unsigned k = 0; k < n; k++) tick(1'b0, 1'b0, 2'd2, 8'h00);
   endtask

   initial begin
      int unsigned n, base, r;
      logic [1:0]  a;
      logic [7:0]  d;

      tick(1'b1, 1'b0, 2'd2, 8'h00);
      tick(1'b1, 1'b0, 2'd2, 8'h00);
      chk("reset_status", bus.rdata, 32'h4);

      // Single DATA byte: enable high after edges N+3..N+6, busy ends after 50-cycle gap.
      tick(1'b0, 1'b1, 2'd0, 8'h41);
      n = cyc;
      idle(60);
      chk("data_rise_edge", last_rise, n + 3);
      chk("data_fall_edge", last_fall, n + 7);
      chk("data_busy_last", last_busy, n + 58);

      tick(1'b0, 1'b1, 2'd1, 8'h01);
      n = cyc;
      idle(2020);
      chk("clear_busy_last", last_busy, n + 2008);
      tick(1'b0, 1'b1, 2'd1, 8'h38);
      n = cyc;
      idle(60);
      chk("cmd_busy_last", last_busy, n + 58);

      // Overflow while the FSM sits in its slow wait.
      tick(1'b0, 1'b1, 2'd1, 8'h01);
      idle(15);
      rise_data.delete();
      for (int unsigned i = 0; i < 9; i++) tick(1'b0, 1'b1, 2'd0, 8'(8'h30 + i));
      tick(1'b0, 1'b0, 2'd2, 8'h00);
      chk("ovf_status", 32'(bus.rdata[8:0]), 32'h08B);
      for (int k = 0; k < 3000 && busy; k++) tick(1'b0, 1'b0, 2'd2, 8'h00);
      chk("drain_done", 32'(busy), 32'h0);
      chk("drain_count", rise_data.size(), 8);
      for (int unsigned i = 0; i < 8 && i < rise_data.size(); i++)
         chk("drain_order", 32'(rise_data[i]), 32'h30 + i);
      tick(1'b0, 1'b1, 2'd2, 8'h02);
      tick(1'b0, 1'b0, 2'd2, 8'h00);
      chk("ovf_cleared", 32'(bus.rdata[3]), 32'h0);

      // Flush during the first byte's pulse.
      base = n_rise;
      for (int unsigned i = 0; i < 6; i++) tick(1'b0, 1'b1, 2'd0, 8'(8'h50 + i));
      tick(1'b0, 1'b1, 2'd2, 8'h01);
      idle(80);
      chk("flush_pulses", n_rise - base, 1);
      chk("flush_empty", 32'(bus.rdata[2]), 32'h1);

      // Reset in the middle of a pulse.
      tick(1'b0, 1'b1, 2'd0, 8'h11);
      idle(3);
      chk("pre_reset_enable", 32'(lcd_enable), 32'h1);
      tick(1'b1, 1'b0, 2'd2, 8'h00);
      chk("reset_enable", 32'(lcd_enable), 32'h0);
      chk("reset_data", 32'(lcd_data), 32'h0);
      tick(1'b0, 1'b1, 2'd0, 8'h5A);
      n = cyc;
      idle(65);
      chk("post_reset_rise", last_rise, n + 3);

      // Push on the exact edge a full FIFO is popped: push is still dropped.
      tick(1'b0, 1'b1, 2'd1, 8'h01);
      idle(3);
      for (int unsigned i = 0; i < 8; i++) tick(1'b0, 1'b1, 2'd0, 8'(8'h60 + i));
      for (int k = 0; k < 2100 && !(m_act && cyc + 1 > m_end); k++) tick(1'b0, 1'b0, 2'd2, 8'h00);
      chk("reached_pop_edge", 32'(m_act && cyc + 1 > m_end), 32'h1);
      tick(1'b0, 1'b1, 2'd0, 8'hEE);
      tick(1'b0, 1'b0, 2'd2, 8'h00);
      chk("same_edge_ovf", 32'(bus.rdata[3]), 32'h1);
      chk("same_edge_count", 32'(bus.rdata[8:4]), 32'h7);
      tick(1'b0, 1'b1, 2'd2, 8'h02);
      tick(1'b0, 1'b0, 2'd2, 8'h00);
      chk("same_edge_ovf_clr", 32'(bus.rdata[3]), 32'h0);

      // Random traffic.
      for (int unsigned k = 0; k < 4000; k++) begin
         r = $urandom_range(0, 999);
         if (r < 2) begin
            tick(1'b1, 1'b0, 2'd2, 8'h00);
         end else if (r < 250) begin
            a = 2'($urandom_range(0, 1));
            d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            tick(1'b0, 1'b1, a, d);
         end else if (r < 270) begin
            tick(1'b0, 1'b1, 2'd2, 8'($urandom_range(0, 3)));
         end else if (r < 285) begin
            tick(1'b0, 1'b1, 2'd3, 8'($urandom));
         end else begin
            tick(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'h00);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
